ama_riscv_mem_arb: RTL and testbench

- Arbitrates a single shared word-wide memory port between the instruction-fetch requester and the load/store requester.
- Allows one transaction in flight at a time.
- Data accesses win by default. A starvation counter guarantees fetch progress.
- Sits between the core's fetch/memory stages and the unified memory; requests use the valid/ready convention, responses are registered one-cycle pulses.

---
 rtl/ama_riscv_mem_arb_if.sv | 50 +++++
 rtl/ama_riscv_mem_arb.sv | 155 +++++++++++++++
 tb/tb_ama_riscv_mem_arb.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_mem_arb_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and
// the shared memory port.
interface ama_riscv_mem_arb_if #(
   parameter int AW = 14,
   parameter int DW = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [AW-1:0]   imem_req_addr;
   logic            imem_rsp_valid;
   logic [DW-1:0]   imem_rsp_data;

   logic            dmem_req_valid;
   logic            dmem_req_ready;
   logic [AW-1:0]   dmem_req_addr;
   logic            dmem_req_we;
   logic [DW/8-1:0] dmem_req_wstrb;
   logic [DW-1:0]   dmem_req_wdata;
   logic            dmem_rsp_valid;
   logic [DW-1:0]   dmem_rsp_data;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [DW/8-1:0] mem_wstrb;
   logic [DW-1:0]   mem_wdata;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rsp_data;

   modport master (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  dmem_req_valid, dmem_req_addr, dmem_req_we,
      input  dmem_req_wstrb, dmem_req_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
      output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data
   );

   modport slave (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output dmem_req_valid, dmem_req_addr, dmem_req_we,
      output dmem_req_wstrb, dmem_req_wdata,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
      input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/ama_riscv_mem_arb.sv
// Shared memory port arbiter: data wins by default, a starvation
// counter forces fetch through after STARVE_LIM blocking data grants.
module ama_riscv_mem_arb #(
   parameter int          AW         = 14,
   parameter int          DW         = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic clk,
   input  logic rst,
   ama_riscv_mem_arb_if.master bus,
   output logic busy,
   output logic err_unexp_rsp
);
   localparam int SW = DW/8;
   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IMEM,
      OWN_DMEM
   } owner_t;

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [3:0]    starve_q, starve_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          irsp_v_q, irsp_v_d;
   logic [DW-1:0] irsp_data_q, irsp_data_d;
   logic          drsp_v_q, drsp_v_d;
   logic [DW-1:0] drsp_data_q, drsp_data_d;
   logic          err_q, err_d;

   logic          grant_i;
   logic          grant_d;

   // Fetch wins only when alone or when starved to the limit.
   always_comb begin
      grant_i = bus.imem_req_valid &&
                (!bus.dmem_req_valid || starve_q == LIM);
      grant_d = bus.dmem_req_valid && !grant_i;
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      irsp_v_d    = 1'b0;
      irsp_data_d = irsp_data_q;
      drsp_v_d    = 1'b0;
      drsp_data_d = drsp_data_q;
      err_d       = err_q ||
                    (bus.mem_rsp_valid && state_q != WAIT_RSP);

      unique case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d  = ISSUE;
               owner_d  = OWN_IMEM;
               starve_d = 4'd0;
               addr_d   = bus.imem_req_addr;
               we_d     = 1'b0;
               wstrb_d  = '0;
               wdata_d  = '0;
            end else if (grant_d) begin
               state_d = ISSUE;
               owner_d = OWN_DMEM;
               addr_d  = bus.dmem_req_addr;
               we_d    = bus.dmem_req_we;
               wstrb_d = bus.dmem_req_wstrb;
               wdata_d = bus.dmem_req_wdata;
               if (bus.imem_req_valid && starve_q < LIM)
                  starve_d = starve_q + 4'd1;
            end
         end
         ISSUE: begin
            if (bus.mem_req_ready)
               state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (bus.mem_rsp_valid) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
               if (owner_q == OWN_IMEM) begin
                  irsp_v_d    = 1'b1;
                  irsp_data_d = bus.mem_rsp_data;
               end else if (owner_q == OWN_DMEM) begin
                  drsp_v_d    = 1'b1;
                  drsp_data_d = we_q ? '0 : bus.mem_rsp_data;
               end
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         starve_q    <= 4'd0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wstrb_q     <= '0;
         wdata_q     <= '0;
         irsp_v_q    <= 1'b0;
         irsp_data_q <= '0;
         drsp_v_q    <= 1'b0;
         drsp_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         irsp_v_q    <= irsp_v_d;
         irsp_data_q <= irsp_data_d;
         drsp_v_q    <= drsp_v_d;
         drsp_data_q <= drsp_data_d;
         err_q       <= err_d;
      end
   end

   assign bus.imem_req_ready = (state_q == IDLE) && grant_i;
   assign bus.dmem_req_ready = (state_q == IDLE) && grant_d;
   assign bus.imem_rsp_valid = irsp_v_q;
   assign bus.imem_rsp_data  = irsp_data_q;
   assign bus.dmem_rsp_valid = drsp_v_q;
   assign bus.dmem_rsp_data  = drsp_data_q;
   assign bus.mem_req_valid  = (state_q == ISSUE);
   assign bus.mem_addr       = addr_q;
   assign bus.mem_we         = we_q;
   assign bus.mem_wstrb      = wstrb_q;
   assign bus.mem_wdata      = wdata_q;
   assign busy               = (state_q != IDLE);
   assign err_unexp_rsp      = err_q;
endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Bench for ama_riscv_mem_arb: memory responder, response scoreboard,
// vector table and hand-written corner sequences.
module tb_ama_riscv_mem_arb;
   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic err;

   always #5 clk = ~clk;

   ama_riscv_mem_arb_if #(.AW(AW), .DW(DW)) bus();

   ama_riscv_mem_arb #(
      .AW(AW), .DW(DW), .STARVE_LIM(LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy),
      .err_unexp_rsp(err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit            is_d;
      bit            we;
      logic [AW-1:0] addr;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] wdata;
      int            rwait;
      logic [DW-1:0] exp;
   } vec_t;

   int ready_wait = 0;
   int inj_req    = 0;
   logic [31:0] mem_m [int];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory side: stalls ready by ready_wait, answers the cycle after
   // the handshake, and can inject a stray response on request.
   initial begin : responder
      int          wcnt;
      int          inj_done;
      bit          hs;
      logic [AW-1:0] ca;
      bit          cwe;
      logic [3:0]  cs;
      logic [31:0] cd;
      logic [31:0] rd;
      wcnt = 0;
      inj_done = 0;
      hs = 0;
      ca = '0;
      cwe = 0;
      cs = '0;
      cd = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         bus.mem_rsp_valid = 1'b0;
         bus.mem_req_ready = 1'b0;
         if (rst) begin
            hs = 0;
            wcnt = 0;
         end else begin
            if (hs) begin
               rd = mem_m.exists(int'(ca)) ? mem_m[int'(ca)]
                                          : (32'hC0DE_0000 | 32'(ca));
               if (cwe) begin
                  for (int b = 0; b < 4; b++)
                     if (cs[b]) rd[8*b +: 8] = cd[8*b +: 8];
                  mem_m[int'(ca)] = rd;
                  bus.mem_rsp_data = ~rd;
               end else begin
                  bus.mem_rsp_data = rd;
               end
               bus.mem_rsp_valid = 1'b1;
               hs = 0;
            end else if (inj_done != inj_req) begin
               inj_done++;
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_data  = 32'hFFFF_FFFF;
            end
            if (bus.mem_req_valid) begin
               if (wcnt >= ready_wait) begin
                  bus.mem_req_ready = 1'b1;
                  hs  = 1;
                  ca  = bus.mem_addr;
                  cwe = bus.mem_we;
                  cs  = bus.mem_wstrb;
                  cd  = bus.mem_wdata;
                  wcnt = 0;
               end else begin
                  wcnt++;
               end
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (bus.imem_rsp_valid || bus.dmem_rsp_valid)) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_rsp: i=%0b d=%0b, none pending",
                        bus.imem_rsp_valid, bus.dmem_rsp_valid);
            end else begin
               e = sb.pop_front();
               check("rsp_excl",
                     {31'd0, bus.imem_rsp_valid && bus.dmem_rsp_valid},
                     32'd0);
               check("rsp_owner_d", {31'd0, bus.dmem_rsp_valid},
                     {31'd0, e.is_d});
               check("rsp_data",
                     e.is_d ? bus.dmem_rsp_data : bus.imem_rsp_data,
                     e.data);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_zero(string p);
      check({p, "_iready"}, {31'd0, bus.imem_req_ready}, 0);
      check({p, "_dready"}, {31'd0, bus.dmem_req_ready}, 0);
      check({p, "_irspv"}, {31'd0, bus.imem_rsp_valid}, 0);
      check({p, "_drspv"}, {31'd0, bus.dmem_rsp_valid}, 0);
      check({p, "_irspd"}, bus.imem_rsp_data, 0);
      check({p, "_drspd"}, bus.dmem_rsp_data, 0);
      check({p, "_mvalid"}, {31'd0, bus.mem_req_valid}, 0);
      check({p, "_maddr"}, 32'(bus.mem_addr), 0);
      check({p, "_mwe"}, {31'd0, bus.mem_we}, 0);
      check({p, "_mwstrb"}, 32'(bus.mem_wstrb), 0);
      check({p, "_mwdata"}, bus.mem_wdata, 0);
      check({p, "_busy"}, {31'd0, busy}, 0);
      check({p, "_err"}, {31'd0, err}, 0);
   endtask

   task automatic idle_inputs();
      bus.imem_req_valid = 1'b0;
      bus.imem_req_addr  = '0;
      bus.dmem_req_valid = 1'b0;
      bus.dmem_req_addr  = '0;
      bus.dmem_req_we    = 1'b0;
      bus.dmem_req_wstrb = '0;
      bus.dmem_req_wdata = '0;
   endtask

   task automatic drive_req(vec_t v, output int acc);
      bit got;
      got = 0;
      acc = 0;
      ready_wait = v.rwait;
      if (v.is_d) begin
         bus.dmem_req_valid = 1'b1;
         bus.dmem_req_addr  = v.addr;
         bus.dmem_req_we    = v.we;
         bus.dmem_req_wstrb = v.wstrb;
         bus.dmem_req_wdata = v.wdata;
      end else begin
         bus.imem_req_valid = 1'b1;
         bus.imem_req_addr  = v.addr;
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (v.is_d ? bus.dmem_req_ready : bus.imem_req_ready) begin
            got = 1;
            break;
         end
      end
      check("accept", {31'd0, got}, 1);
      if (got) begin
         sb.push_back('{is_d: v.is_d, data: v.exp});
         acc = cyc;
      end
      @(posedge clk);
      #1;
      bus.imem_req_valid = 1'b0;
      bus.dmem_req_valid = 1'b0;
      bus.dmem_req_addr  = 14'h3ABC;
      bus.dmem_req_wdata = 32'h0BAD_F00D;
      bus.dmem_req_wstrb = 4'hF;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      check("drain", {31'd0, ok}, 1);
      @(posedge clk);
      #1;
   endtask

   vec_t vt[12];
   int   acc;
   int   accs[4];
   int   n;
   int   last_v;
   int   rsp_k;
   string ord;
   logic [AW-1:0] ia, da;
   bit   gi, gd;

   initial begin : main
      vt[0]  = '{0, 0, 14'h0100, 4'h0, 32'h0, 0, 32'hC0DE_0100};
      vt[1]  = '{1, 0, 14'h0200, 4'h0, 32'h0, 0, 32'hC0DE_0200};
      vt[2]  = '{1, 0, 14'h0040, 4'h0, 32'h0, 0, 32'hC0DE_BEEF};
      vt[3]  = '{1, 1, 14'h0040, 4'hC, 32'h1234_5678, 1, 32'h0};
      vt[4]  = '{1, 0, 14'h0040, 4'h0, 32'h0, 0, 32'h1234_BEEF};
      vt[5]  = '{0, 0, 14'h0040, 4'h0, 32'h0, 0, 32'h1234_BEEF};
      vt[6]  = '{1, 1, 14'h3FFF, 4'hF, 32'hA5A5_5A5A, 2, 32'h0};
      vt[7]  = '{0, 0, 14'h3FFF, 4'h0, 32'h0, 0, 32'hA5A5_5A5A};
      vt[8]  = '{1, 1, 14'h1000, 4'h1, 32'h0000_00FF, 0, 32'h0};
      vt[9]  = '{0, 0, 14'h1000, 4'h0, 32'h0, 0, 32'h0000_00FF};
      vt[10] = '{1, 0, 14'h0000, 4'h0, 32'h0, 5, 32'hC0DE_0000};
      vt[11] = '{0, 0, 14'h0000, 4'h0, 32'h0, 0, 32'hC0DE_0000};

      idle_inputs();
      mem_m[32'h1000] = 32'h0000_0013;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // fetch at minimum latency
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = 14'h1000;
      @(negedge clk);
      check("t1_iready", {31'd0, bus.imem_req_ready}, 1);
      check("t1_dready", {31'd0, bus.dmem_req_ready}, 0);
      if (bus.imem_req_ready)
         sb.push_back('{is_d: 0, data: 32'h0000_0013});
      @(posedge clk);
      #1;
      bus.imem_req_valid = 1'b0;
      @(negedge clk);
      check("t1_mvalid", {31'd0, bus.mem_req_valid}, 1);
      check("t1_maddr", 32'(bus.mem_addr), 32'h1000);
      check("t1_mwe", {31'd0, bus.mem_we}, 0);
      check("t1_iready_issue", {31'd0, bus.imem_req_ready}, 0);
      @(negedge clk);
      check("t1_mvalid_drop", {31'd0, bus.mem_req_valid}, 0);
      check("t1_busy", {31'd0, busy}, 1);
      @(negedge clk);
      check("t1_irspv", {31'd0, bus.imem_rsp_valid}, 1);
      check("t1_irspd", bus.imem_rsp_data, 32'h13);
      check("t1_drspv", {31'd0, bus.dmem_rsp_valid}, 0);
      check("t1_idle", {31'd0, busy}, 0);
      @(negedge clk);
      check("t1_pulse", {31'd0, bus.imem_rsp_valid}, 0);
      @(posedge clk);
      #1;

      // store with the port stalling ready for three cycles
      drive_req('{1, 1, 14'h0040, 4'h3, 32'hDEAD_BEEF, 3, 32'h0}, acc);
      n = 0;
      last_v = -1;
      rsp_k = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.mem_req_valid) begin
            n++;
            last_v = k;
            check("st_addr", 32'(bus.mem_addr), 32'h0040);
            check("st_we", {31'd0, bus.mem_we}, 1);
            check("st_wstrb", 32'(bus.mem_wstrb), 32'h3);
            check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         end
         if (bus.dmem_rsp_valid && rsp_k < 0) rsp_k = k;
      end
      check("st_valid_cycles", 32'(n), 4);
      check("st_rsp_delay", 32'(rsp_k - last_v), 2);
      ready_wait = 0;
      wait_drain();

      for (int i = 0; i < 12; i++) begin
         drive_req(vt[i], acc);
         wait_drain();
      end

      // back-to-back loads, fetch idle
      n = 0;
      da = 14'h2100;
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_we    = 1'b0;
      bus.dmem_req_addr  = da;
      for (int k = 0; k < 40 && n < 4; k++) begin
         @(negedge clk);
         gd = bus.dmem_req_ready;
         if (gd) begin
            sb.push_back('{is_d: 1, data: 32'hC0DE_0000 | 32'(da)});
            accs[n] = cyc;
            n++;
         end
         @(posedge clk);
         #1;
         if (gd) begin
            da = da + 14'd1;
            bus.dmem_req_addr = da;
         end
         if (n == 4) bus.dmem_req_valid = 1'b0;
      end
      bus.dmem_req_valid = 1'b0;
      check("b2b_count", 32'(n), 4);
      for (int i = 1; i < 4; i++)
         check("b2b_gap", 32'(accs[i] - accs[i-1]), 3);
      wait_drain();

      // both requesters continuously valid
      ord = "";
      ia = 14'h3000;
      da = 14'h2000;
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = ia;
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_we    = 1'b0;
      bus.dmem_req_addr  = da;
      for (int k = 0; k < 200 && ord.len() < 10; k++) begin
         @(negedge clk);
         gi = bus.imem_req_ready;
         gd = bus.dmem_req_ready;
         if (gi) begin
            ord = {ord, "I"};
            sb.push_back('{is_d: 0, data: 32'hC0DE_0000 | 32'(ia)});
         end
         if (gd) begin
            ord = {ord, "D"};
            sb.push_back('{is_d: 1, data: 32'hC0DE_0000 | 32'(da)});
         end
         @(posedge clk);
         #1;
         if (gi) begin
            ia = ia + 14'd1;
            bus.imem_req_addr = ia;
         end
         if (gd) begin
            da = da + 14'd1;
            bus.dmem_req_addr = da;
         end
      end
      bus.imem_req_valid = 1'b0;
      bus.dmem_req_valid = 1'b0;
      total++;
      if (ord != "DDDDIDDDDI") begin
         bad++;
         $display("FAIL grant_order: got %s want DDDDIDDDDI", ord);
      end
      wait_drain();

      // stray response while idle
      inj_req++;
      repeat (3) @(negedge clk);
      check("err_set", {31'd0, err}, 1);
      check("err_idle", {31'd0, busy}, 0);
      repeat (4) @(negedge clk);
      check("err_sticky", {31'd0, err}, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("err_rst", {31'd0, err}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of a load
      ready_wait = 0;
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_we    = 1'b0;
      bus.dmem_req_addr  = 14'h0200;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.dmem_req_ready) begin
            n = 1;
            break;
         end
      end
      check("mr_accept", 32'(n), 1);
      sb.push_back('{is_d: 1, data: 32'hC0DE_0200});
      @(posedge clk);
      #1;
      bus.dmem_req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      check("mr_wait_busy", {31'd0, busy}, 1);
      check("mr_wait_mvalid", {31'd0, bus.mem_req_valid}, 0);
      rst = 1'b1;
      #1;
      check_zero("mr");
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.dmem_rsp_valid) n++;
      end
      check("mr_no_rsp", 32'(n), 0);
      check("mr_no_err", {31'd0, err}, 0);
      @(posedge clk);
      #1;
      drive_req('{0, 0, 14'h0500, 4'h0, 32'h0, 0, 32'hC0DE_0500}, acc);
      wait_drain();

      check("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
